// File: rtl/mem_ctrl_pkg.sv
// Shared types and default geometry for the memory request front-end.
package mem_ctrl_pkg;

  localparam int unsigned MEM_ADDR_W = 10;
  localparam int unsigned MEM_DATA_W = 8;

  // INIT sweeps the array once after reset; IDLE serves requests until the next reset.
  typedef enum logic [0:0] {
    INIT,
    IDLE
  } mem_ctrl_state_e;

endpackage

// File: rtl/mem_init_seq.sv
// Post-reset clear sequencer: walks every memory address once, one per cycle.
module mem_init_seq
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W = MEM_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  output logic              sweep_wen,
  output logic [ADDR_W-1:0] sweep_addr,
  output logic              sweep_last
);

  // One spare bit so the terminal compare never aliases with a wrapped count.
  localparam logic [ADDR_W:0] LastAddr = {1'b0, {ADDR_W{1'b1}}};

  logic [ADDR_W:0] cnt_q, cnt_d;

  // Advance the sweep only while the controller is in its init phase.
  always_comb begin
    cnt_d = cnt_q;
    if (en) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Sweep counter; restarts from address 0 on every reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Write strobe, address and final-location flag for the current sweep step.
  always_comb begin
    sweep_wen  = en;
    sweep_addr = cnt_q[ADDR_W-1:0];
    sweep_last = en && (cnt_q == LastAddr);
  end

endmodule

// File: rtl/mem_req_ctrl.sv
// Request front-end for the banked memory: init sweep, then single-beat
// read/write requests with a registered read-response channel.
module mem_req_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned       ADDR_W   = MEM_ADDR_W,
  parameter int unsigned       DATA_W   = MEM_DATA_W,
  parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              init_done,
  output logic              mem_wen,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  mem_ctrl_state_e state_q, state_d;

  logic              sweep_en;
  logic              sweep_wen;
  logic [ADDR_W-1:0] sweep_addr;
  logic              sweep_last;

  logic              rd_acc;
  logic              wr_acc;
  logic              rsp_valid_q;
  logic [DATA_W-1:0] rsp_data_q;
  logic [ADDR_W-1:0] last_addr_q;

  assign sweep_en = (state_q == INIT);

  mem_init_seq #(
    .ADDR_W(ADDR_W)
  ) u_init_seq (
    .clk       (clk),
    .rst       (rst),
    .en        (sweep_en),
    .sweep_wen (sweep_wen),
    .sweep_addr(sweep_addr),
    .sweep_last(sweep_last)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= INIT;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: leave INIT after the last sweep write; IDLE is absorbing.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      INIT:    if (sweep_last) state_d = IDLE;
      IDLE:    state_d = IDLE;
      default: state_d = INIT;
    endcase
  end

  // Outputs and accept decode; memory-side ports are forced quiet during reset.
  always_comb begin
    req_ready = 1'b0;
    mem_wen   = 1'b0;
    mem_addr  = last_addr_q;
    mem_wdata = req_wdata;
    rd_acc    = 1'b0;
    wr_acc    = 1'b0;
    if (rst) begin
      mem_addr  = '0;
      mem_wdata = '0;
    end else begin
      unique case (state_q)
        INIT: begin
          mem_wen   = sweep_wen;
          mem_addr  = sweep_addr;
          mem_wdata = INIT_VAL;
        end
        IDLE: begin
          // A held response blocks new requests so responses stay in order.
          req_ready = !rsp_valid_q || rsp_ready;
          if (req_valid && req_ready) begin
            mem_addr = req_addr;
            if (req_we) begin
              wr_acc  = 1'b1;
              mem_wen = 1'b1;
            end else begin
              rd_acc = 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Response register and last-address hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      last_addr_q <= '0;
    end else begin
      if (rd_acc) begin
        rsp_valid_q <= 1'b1;
        rsp_data_q  <= mem_rdata;
      end else if (rsp_valid_q && rsp_ready) begin
        rsp_valid_q <= 1'b0;
      end
      if (rd_acc || wr_acc) begin
        last_addr_q <= req_addr;
      end
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign init_done = (state_q == IDLE);

endmodule
